// File: rtl/regbank_pkg.sv
// Shared types and widths for the register-bank writeback arbiter.
// Exports: WIDTH_ADDR_LENGTH, WIDTH_DATA_LENGTH, REG_ZERO, wb_req_t {addr,data}, is_reg_zero().
// Imported by wb_fifo and regbank_wb_arbiter.
package regbank_pkg;

  localparam int WIDTH_ADDR_LENGTH = 5;
  localparam int WIDTH_DATA_LENGTH = 32;

  localparam logic [WIDTH_ADDR_LENGTH-1:0] REG_ZERO = 5'h00;

  // One register-file write: destination and value.
  typedef struct packed {
    logic [WIDTH_ADDR_LENGTH-1:0] addr;
    logic [WIDTH_DATA_LENGTH-1:0] data;
  } wb_req_t;

  // x0 is hardwired to zero; writes to it are consumed but never performed.
  function automatic logic is_reg_zero(input logic [WIDTH_ADDR_LENGTH-1:0] a);
    return a == REG_ZERO;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback requests, DEPTH entries of {addr,data}.
// Ports: push_i/push_dat_i enqueue, pop_i dequeues head_o; full_o/empty_o status;
//        entries_o/valid_o expose every slot so the owner can compare destinations.
module wb_fifo
  import regbank_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  wb_req_t               push_dat_i,
  input  logic                  pop_i,
  output logic                  full_o,
  output logic                  empty_o,
  output wb_req_t               head_o,
  output wb_req_t [DEPTH-1:0]   entries_o,
  output logic    [DEPTH-1:0]   valid_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_req_t            mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic               do_push;
  logic               do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

  // Guard both sides so a misbehaving owner cannot corrupt the count.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = valid_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_o[i] = mem_q[i];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (do_push) begin
      wr_ptr_d          = ptr_inc(wr_ptr_q);
      valid_d[wr_ptr_q] = 1'b1;
    end
    // Push and pop never touch the same slot: a pop needs a non-empty FIFO,
    // and a push needs it not full, so the pointers differ.
    if (do_pop) begin
      rd_ptr_d          = ptr_inc(rd_ptr_q);
      valid_d[rd_ptr_q] = 1'b0;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Storage needs no reset: valid_q masks every stale slot.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

endmodule

// File: rtl/regbank_wb_arbiter.sv
// Shares the single register-bank write port between pipeline writeback and queued MDU results.
// Ports: pipe_* writeback request (pipe_ready holds it), mdu_* result push (mdu_ready),
//        q_addr_*/q_hit_* decode scoreboard lookups, rf_* registered write port to REGBank.
module regbank_wb_arbiter
  import regbank_pkg::*;
#(
  parameter int MDU_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pipe_wen,
  input  logic [WIDTH_ADDR_LENGTH-1:0] pipe_addr,
  input  logic [WIDTH_DATA_LENGTH-1:0] pipe_data,
  output logic                         pipe_ready,
  input  logic                         mdu_valid,
  input  logic [WIDTH_ADDR_LENGTH-1:0] mdu_addr,
  input  logic [WIDTH_DATA_LENGTH-1:0] mdu_data,
  output logic                         mdu_ready,
  input  logic [WIDTH_ADDR_LENGTH-1:0] q_addr_a,
  input  logic [WIDTH_ADDR_LENGTH-1:0] q_addr_b,
  output logic                         q_hit_a,
  output logic                         q_hit_b,
  output logic                         rf_wen,
  output logic [WIDTH_ADDR_LENGTH-1:0] rf_addr,
  output logic [WIDTH_DATA_LENGTH-1:0] rf_data
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  logic                         fifo_full;
  logic                         fifo_empty;
  wb_req_t                      fifo_head;
  wb_req_t  [MDU_DEPTH-1:0]     fifo_entries;
  logic     [MDU_DEPTH-1:0]     fifo_valid;
  wb_req_t                      mdu_req;
  logic                         mdu_push;

  logic [SC_W-1:0]              starve_q, starve_d;
  logic                         force_mdu;
  logic                         grant_mdu;
  logic                         grant_pipe;

  logic                         rf_wen_q, rf_wen_d;
  logic [WIDTH_ADDR_LENGTH-1:0] rf_addr_q, rf_addr_d;
  logic [WIDTH_DATA_LENGTH-1:0] rf_data_q, rf_data_d;

  // ---------------------------------------------------------------------------
  // MDU result queue
  // ---------------------------------------------------------------------------
  assign mdu_ready    = !rst && !fifo_full;
  assign mdu_push     = mdu_valid && mdu_ready;
  assign mdu_req.addr = mdu_addr;
  assign mdu_req.data = mdu_data;

  wb_fifo #(
    .DEPTH (MDU_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (mdu_push),
    .push_dat_i (mdu_req),
    .pop_i      (grant_mdu),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_o     (fifo_head),
    .entries_o  (fifo_entries),
    .valid_o    (fifo_valid)
  );

  // ---------------------------------------------------------------------------
  // Arbitration. Decisions use the registered FIFO state only, so a result
  // pushed this cycle cannot be granted until the next one.
  // ---------------------------------------------------------------------------
  assign force_mdu  = !fifo_empty && (starve_q == SC_W'(STARVE_LIMIT));
  assign pipe_ready = !force_mdu;

  always_comb begin
    grant_mdu  = 1'b0;
    grant_pipe = 1'b0;
    if (force_mdu) begin
      grant_mdu = 1'b1;
    end else if (pipe_wen) begin
      grant_pipe = 1'b1;
    end else if (!fifo_empty) begin
      grant_mdu = 1'b1;
    end
  end

  // Counts consecutive losses of a waiting MDU result; saturates at the limit,
  // where force_mdu takes over and the next cycle clears it.
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || grant_mdu) begin
      starve_d = '0;
    end else if (grant_pipe && (starve_q != SC_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + SC_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Output register. Winner lands on rf_* one cycle after the grant; address
  // and data hold through idle cycles so REGBank sees stable values.
  // ---------------------------------------------------------------------------
  always_comb begin
    rf_wen_d  = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    if (grant_mdu) begin
      rf_wen_d  = !is_reg_zero(fifo_head.addr);
      rf_addr_d = fifo_head.addr;
      rf_data_d = fifo_head.data;
    end else if (grant_pipe) begin
      rf_wen_d  = !is_reg_zero(pipe_addr);
      rf_addr_d = pipe_addr;
      rf_data_d = pipe_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q  <= '0;
      rf_wen_q  <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      starve_q  <= starve_d;
      rf_wen_q  <= rf_wen_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
    end
  end

  assign rf_wen  = rf_wen_q;
  assign rf_addr = rf_addr_q;
  assign rf_data = rf_data_q;

  // ---------------------------------------------------------------------------
  // Scoreboard: a register is busy while an MDU write for it is queued or is
  // sitting on the write port. x0 is never busy.
  // ---------------------------------------------------------------------------
  always_comb begin
    q_hit_a = 1'b0;
    q_hit_b = 1'b0;
    for (int i = 0; i < MDU_DEPTH; i++) begin
      if (fifo_valid[i] && (fifo_entries[i].addr == q_addr_a)) q_hit_a = 1'b1;
      if (fifo_valid[i] && (fifo_entries[i].addr == q_addr_b)) q_hit_b = 1'b1;
    end
    if (rf_wen_q && (rf_addr_q == q_addr_a)) q_hit_a = 1'b1;
    if (rf_wen_q && (rf_addr_q == q_addr_b)) q_hit_b = 1'b1;
    if (is_reg_zero(q_addr_a)) q_hit_a = 1'b0;
    if (is_reg_zero(q_addr_b)) q_hit_b = 1'b0;
  end

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Directed bench for regbank_wb_arbiter with hand-computed expectations.
// Inputs are driven 1 time unit after posedge; outputs are sampled 1-2 units after posedge.
// A small register-file model captures rf_* on negedge, like REGBank.
module tb_regbank_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        pipe_wen;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        pipe_ready;
  logic        mdu_valid;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic [4:0]  q_addr_a;
  logic [4:0]  q_addr_b;
  logic        q_hit_a;
  logic        q_hit_b;
  logic        rf_wen;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;

  int n_checks;
  int n_errors;

  logic [31:0] rf_model [32];

  regbank_wb_arbiter #(
    .MDU_DEPTH    (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_wen   (pipe_wen),
    .pipe_addr  (pipe_addr),
    .pipe_data  (pipe_data),
    .pipe_ready (pipe_ready),
    .mdu_valid  (mdu_valid),
    .mdu_addr   (mdu_addr),
    .mdu_data   (mdu_data),
    .mdu_ready  (mdu_ready),
    .q_addr_a   (q_addr_a),
    .q_addr_b   (q_addr_b),
    .q_hit_a    (q_hit_a),
    .q_hit_b    (q_hit_b),
    .rf_wen     (rf_wen),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rf_wen) rf_model[rf_addr] = rf_data;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pipe(input logic wen, input logic [4:0] a, input logic [31:0] d);
    pipe_wen  = wen;
    pipe_addr = a;
    pipe_data = d;
  endtask

  task automatic drive_mdu(input logic v, input logic [4:0] a, input logic [31:0] d);
    mdu_valid = v;
    mdu_addr  = a;
    mdu_data  = d;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 32; i++) rf_model[i] = '0;

    // ---- 1: reset with mdu_valid held high
    rst = 1'b1;
    drive_pipe(1'b0, 5'd0, 32'h0);
    drive_mdu(1'b1, 5'd3, 32'h33);
    q_addr_a = 5'd3;
    q_addr_b = 5'd0;
    tick();
    tick();
    chk_eq("rst_rf_wen", rf_wen, 1'b0);
    chk_eq("rst_rf_addr", rf_addr, 5'd0);
    chk_eq("rst_rf_data", rf_data, 32'h0);
    chk_eq("rst_mdu_ready", mdu_ready, 1'b0);
    chk_eq("rst_hit_a", q_hit_a, 1'b0);
    rst = 1'b0;
    drive_mdu(1'b0, 5'd0, 32'h0);
    #1;
    chk_eq("post_rst_mdu_ready", mdu_ready, 1'b1);
    tick();
    chk_eq("rst_no_push_hit", q_hit_a, 1'b0);
    chk_eq("rst_no_push_wen", rf_wen, 1'b0);

    // ---- 2: pipeline write only
    drive_pipe(1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    chk_eq("pipe_ready", pipe_ready, 1'b1);
    tick();
    drive_pipe(1'b0, 5'd0, 32'h0);
    chk_eq("pipe_rf_wen", rf_wen, 1'b1);
    chk_eq("pipe_rf_addr", rf_addr, 5'd5);
    chk_eq("pipe_rf_data", rf_data, 32'hDEADBEEF);
    tick();
    chk_eq("idle_rf_wen", rf_wen, 1'b0);
    chk_eq("idle_rf_addr_hold", rf_addr, 5'd5);
    chk_eq("idle_rf_data_hold", rf_data, 32'hDEADBEEF);
    chk_eq("regbank_x5", rf_model[5], 32'hDEADBEEF);

    // ---- 3: MDU result drained into an idle slot
    drive_mdu(1'b1, 5'd7, 32'h11);
    q_addr_a = 5'd7;
    #1;
    chk_eq("drain_hit_before_push", q_hit_a, 1'b0);
    tick();
    drive_mdu(1'b0, 5'd0, 32'h0);
    chk_eq("drain_hit_queued", q_hit_a, 1'b1);
    chk_eq("drain_no_bypass", rf_wen, 1'b0);
    tick();
    chk_eq("drain_rf_wen", rf_wen, 1'b1);
    chk_eq("drain_rf_addr", rf_addr, 5'd7);
    chk_eq("drain_rf_data", rf_data, 32'h11);
    chk_eq("drain_hit_inflight", q_hit_a, 1'b1);
    tick();
    chk_eq("drain_done_wen", rf_wen, 1'b0);
    chk_eq("drain_hit_clear", q_hit_a, 1'b0);

    // ---- 4: starvation limit with pipe busy every cycle
    drive_mdu(1'b1, 5'd9, 32'h22);
    drive_pipe(1'b1, 5'd10, 32'h100);
    tick();
    drive_mdu(1'b0, 5'd0, 32'h0);
    chk_eq("starve_push_cycle_pipe", rf_addr, 5'd10);
    for (int k = 1; k <= 4; k++) begin
      drive_pipe(1'b1, 5'(10 + k), 32'h100 + k);
      #1;
      chk_eq($sformatf("starve_ready_%0d", k), pipe_ready, 1'b1);
      tick();
      chk_eq($sformatf("starve_pipe_win_%0d", k), rf_addr, 5'(10 + k));
    end
    drive_pipe(1'b1, 5'd20, 32'h200);
    #1;
    chk_eq("starve_force_ready", pipe_ready, 1'b0);
    tick();
    chk_eq("starve_mdu_addr", rf_addr, 5'd9);
    chk_eq("starve_mdu_data", rf_data, 32'h22);
    chk_eq("starve_mdu_wen", rf_wen, 1'b1);
    chk_eq("starve_after_ready", pipe_ready, 1'b1);
    tick();
    chk_eq("starve_held_pipe_addr", rf_addr, 5'd20);
    chk_eq("starve_held_pipe_data", rf_data, 32'h200);

    // ---- 5: fill, full, push+pop across pointer wrap
    drive_pipe(1'b1, 5'd1, 32'h0);
    drive_mdu(1'b1, 5'd11, 32'hA1);
    tick();
    drive_mdu(1'b1, 5'd12, 32'hA2);
    tick();
    drive_mdu(1'b1, 5'd13, 32'hBAD);
    #1;
    chk_eq("full_mdu_ready", mdu_ready, 1'b0);
    tick();
    drive_pipe(1'b0, 5'd0, 32'h0);
    drive_mdu(1'b0, 5'd0, 32'h0);
    tick();
    chk_eq("fifo_pop1_addr", rf_addr, 5'd11);
    chk_eq("fifo_pop1_data", rf_data, 32'hA1);
    drive_mdu(1'b1, 5'd13, 32'hA3);
    #1;
    chk_eq("count1_mdu_ready", mdu_ready, 1'b1);
    tick();
    drive_mdu(1'b0, 5'd0, 32'h0);
    q_addr_b = 5'd13;
    #1;
    chk_eq("fifo_pop2_addr", rf_addr, 5'd12);
    chk_eq("fifo_pop2_data", rf_data, 32'hA2);
    chk_eq("pushpop_count1_ready", mdu_ready, 1'b1);
    chk_eq("wrap_hit_b", q_hit_b, 1'b1);
    tick();
    chk_eq("fifo_pop3_addr", rf_addr, 5'd13);
    chk_eq("fifo_pop3_data", rf_data, 32'hA3);
    tick();
    chk_eq("fifo_empty_wen", rf_wen, 1'b0);
    chk_eq("fifo_empty_hit_b", q_hit_b, 1'b0);

    // ---- 6: x0 writes are consumed but never performed
    drive_pipe(1'b1, 5'd0, 32'hFFFFFFFF);
    drive_mdu(1'b1, 5'd0, 32'h55);
    q_addr_a = 5'd0;
    #1;
    chk_eq("x0_pipe_ready", pipe_ready, 1'b1);
    tick();
    drive_pipe(1'b0, 5'd0, 32'h0);
    drive_mdu(1'b0, 5'd0, 32'h0);
    chk_eq("x0_pipe_rf_wen", rf_wen, 1'b0);
    chk_eq("x0_hit_a", q_hit_a, 1'b0);
    tick();
    chk_eq("x0_mdu_rf_wen", rf_wen, 1'b0);
    tick();
    chk_eq("x0_regbank", rf_model[0], 32'h0);
    chk_eq("x0_after_drain_ready", mdu_ready, 1'b1);

    // ---- reset mid-drain discards queued results
    drive_pipe(1'b1, 5'd2, 32'h2);
    drive_mdu(1'b1, 5'd15, 32'h15);
    q_addr_a = 5'd15;
    tick();
    drive_mdu(1'b0, 5'd0, 32'h0);
    #1;
    chk_eq("middrain_hit_before", q_hit_a, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_pipe(1'b0, 5'd0, 32'h0);
    #1;
    chk_eq("middrain_hit_after", q_hit_a, 1'b0);
    chk_eq("middrain_rf_wen", rf_wen, 1'b0);
    tick();
    chk_eq("middrain_no_drain", rf_wen, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
